// File: rtl/antirebote_multi.sv
// antirebote_multi
// Multi-channel push-button debouncer with edge and long-press pulses.
// Every channel is an independent copy of the same pipeline:
//   BTN -> 2-flop synchronizer -> candidate + saturating stability counter
//       -> BTN_estable -> rise/fall pulses, plus a long-press counter.
//
// Ports
//   clk          system clock, all state changes on its rising edge
//   rst          synchronous active-high reset
//   BTN          raw asynchronous button levels, one bit per channel
//   BTN_estable  debounced level per channel
//   pulso_sube   one-cycle pulse in the first cycle BTN_estable shows 1
//   pulso_baja   one-cycle pulse in the first cycle BTN_estable shows 0
//   pulso_largo  one-cycle pulse once per press, the cycle after the channel
//                has been debounced-high for LARGO_CICLOS cycles
module antirebote_multi #(
  parameter int N_CANALES      = 4,
  parameter int ESTABLE_CICLOS = 65536,
  parameter int LARGO_CICLOS   = 50000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CANALES-1:0] BTN,
  output logic [N_CANALES-1:0] BTN_estable,
  output logic [N_CANALES-1:0] pulso_sube,
  output logic [N_CANALES-1:0] pulso_baja,
  output logic [N_CANALES-1:0] pulso_largo
);

  localparam int W_EST = $clog2(ESTABLE_CICLOS + 1);
  localparam int W_LAR = $clog2(LARGO_CICLOS + 1);

  localparam logic [W_EST-1:0] EST_MAX = W_EST'(ESTABLE_CICLOS);
  localparam logic [W_EST-1:0] EST_UNO = W_EST'(1);
  localparam logic [W_LAR-1:0] LAR_MAX = W_LAR'(LARGO_CICLOS);
  localparam logic [W_LAR-1:0] LAR_UNO = W_LAR'(1);

  for (genvar g = 0; g < N_CANALES; g++) begin : g_canal
    logic             sinc1_r;
    logic             sinc2_r;
    logic             cand_r;
    logic [W_EST-1:0] cnt_est_r;
    logic             estable_r;
    logic             sube_r;
    logic             baja_r;
    logic [W_LAR-1:0] cnt_lar_r;
    logic             largo_hecho_r;
    logic             largo_r;
    logic             acepta_s;

    // The candidate has been seen unchanged long enough and differs from the
    // current debounced level. A mismatch on sinc2 this cycle vetoes it,
    // because the candidate reload has priority over everything else.
    assign acepta_s = (sinc2_r == cand_r) && (cnt_est_r == EST_MAX) &&
                      (estable_r != cand_r);

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk) begin
      if (rst) begin
        sinc1_r <= 1'b0;
        sinc2_r <= 1'b0;
      end else begin
        sinc1_r <= BTN[g];
        sinc2_r <= sinc1_r;
      end
    end

    // Candidate level and saturating stability counter.
    always_ff @(posedge clk) begin
      if (rst) begin
        cand_r    <= 1'b0;
        cnt_est_r <= '0;
      end else if (sinc2_r != cand_r) begin
        cand_r    <= sinc2_r;
        cnt_est_r <= '0;
      end else if (cnt_est_r < EST_MAX) begin
        cnt_est_r <= cnt_est_r + EST_UNO;
      end else begin
        cnt_est_r <= cnt_est_r;
      end
    end

    // Debounced level and its registered edge pulses (same edge as the level).
    always_ff @(posedge clk) begin
      if (rst) begin
        estable_r <= 1'b0;
        sube_r    <= 1'b0;
        baja_r    <= 1'b0;
      end else begin
        sube_r <= acepta_s & cand_r;
        baja_r <= acepta_s & ~cand_r;
        if (acepta_s) begin
          estable_r <= cand_r;
        end else begin
          estable_r <= estable_r;
        end
      end
    end

    // Long-press counter; the done flag limits the pulse to one per press.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_lar_r     <= '0;
        largo_hecho_r <= 1'b0;
        largo_r       <= 1'b0;
      end else if (!estable_r) begin
        cnt_lar_r     <= '0;
        largo_hecho_r <= 1'b0;
        largo_r       <= 1'b0;
      end else begin
        if (cnt_lar_r < LAR_MAX) begin
          cnt_lar_r <= cnt_lar_r + LAR_UNO;
        end else begin
          cnt_lar_r <= cnt_lar_r;
        end
        largo_r       <= (cnt_lar_r == LAR_MAX) && !largo_hecho_r;
        largo_hecho_r <= largo_hecho_r | (cnt_lar_r == LAR_MAX);
      end
    end

    assign BTN_estable[g] = estable_r;
    assign pulso_sube[g]  = sube_r;
    assign pulso_baja[g]  = baja_r;
    assign pulso_largo[g] = largo_r;
  end

endmodule

// File: tb/tb_antirebote_multi.sv
// Self-checking bench for antirebote_multi (N=4, ESTABLE=4, LARGO=10).
// The reference model works on the raw sample history: a level is accepted
// once the same BTN value was sampled on ESTABLE+2 consecutive edges ending
// two edges ago; long press counts edges spent debounced-high.
module tb_antirebote_multi;

  localparam int N  = 4;
  localparam int E  = 4;
  localparam int L  = 10;
  localparam int HL = E + 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn;
  logic [N-1:0] est;
  logic [N-1:0] sube;
  logic [N-1:0] baja;
  logic [N-1:0] largo;

  always #5 clk = ~clk;

  antirebote_multi #(
    .N_CANALES     (N),
    .ESTABLE_CICLOS(E),
    .LARGO_CICLOS  (L)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .BTN        (btn),
    .BTN_estable(est),
    .pulso_sube (sube),
    .pulso_baja (baja),
    .pulso_largo(largo)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  bit           m_hist [N][HL];
  logic [N-1:0] m_est   = '0;
  logic [N-1:0] m_sube  = '0;
  logic [N-1:0] m_baja  = '0;
  logic [N-1:0] m_largo = '0;
  int           m_run [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_update();
    for (int c = 0; c < N; c++) begin
      bit v;
      bit all_eq;
      bit prev;
      if (rst) begin
        for (int i = 0; i < HL; i++) m_hist[c][i] = 1'b0;
        m_est[c]   = 1'b0;
        m_sube[c]  = 1'b0;
        m_baja[c]  = 1'b0;
        m_largo[c] = 1'b0;
        m_run[c]   = 0;
      end else begin
        v = m_hist[c][0];
        all_eq = 1'b1;
        for (int i = 1; i <= E + 1; i++) if (m_hist[c][i] != v) all_eq = 1'b0;
        prev = m_est[c];
        m_sube[c] = 1'b0;
        m_baja[c] = 1'b0;
        if (prev) m_run[c] = m_run[c] + 1;
        else m_run[c] = 0;
        m_largo[c] = prev && (m_run[c] == L + 1);
        if (all_eq && (v != prev)) begin
          m_est[c]  = v;
          m_sube[c] = v;
          m_baja[c] = !v;
        end
        for (int i = 0; i < HL - 1; i++) m_hist[c][i] = m_hist[c][i+1];
        m_hist[c][HL-1] = btn[c];
      end
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    if (chk_en) begin
      check("model_estable", 32'(est),   32'(m_est));
      check("model_sube",    32'(sube),  32'(m_sube));
      check("model_baja",    32'(baja),  32'(m_baja));
      check("model_largo",   32'(largo), 32'(m_largo));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int cnt;
    int pos;
    bit acc;
    bit flip_lo;
    logic [7:0] patron;

    for (int c = 0; c < N; c++) begin
      m_run[c] = 0;
      for (int i = 0; i < HL; i++) m_hist[c][i] = 1'b0;
    end
    rst = 1'b1;
    btn = '0;
    tick();
    chk_en = 1'b1;
    ticks(2);
    check("reset_outputs", 32'({est, sube, baja, largo}), 32'd0);
    rst = 1'b0;
    ticks(12);

    // Single rise on channel 0: visible after the 8th edge, pulse for one cycle.
    btn[0] = 1'b1;
    ticks(7);
    check("rise_not_yet", 32'(est[0]), 32'd0);
    tick();
    check("rise_estable", 32'(est[0]), 32'd1);
    check("rise_sube",    32'(sube[0]), 32'd1);
    tick();
    check("rise_sube_off", 32'(sube[0]), 32'd0);
    check("rise_hold",     32'(est[0]), 32'd1);
    btn[0] = 1'b0;
    ticks(8);
    check("fall_baja", 32'(baja[0]), 32'd1);
    ticks(4);

    // Three-cycle glitch on channel 1 must leave all its outputs quiet.
    acc = 1'b0;
    btn[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); acc |= est[1] | sube[1] | baja[1]; end
    btn[1] = 1'b0;
    for (int i = 0; i < 15; i++) begin tick(); acc |= est[1] | sube[1] | baja[1]; end
    check("glitch_quiet", 32'(acc), 32'd0);

    // Bouncing press on channel 2: one rise pulse, one fall pulse 8 edges later.
    patron = 8'b0011_0011;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin btn[2] = patron[i]; tick(); cnt += int'(sube[2]); end
    btn[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin tick(); cnt += int'(sube[2]); end
    check("bounce_one_sube", 32'(cnt), 32'd1);
    btn[2] = 1'b0;
    cnt = 0;
    pos = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (baja[2]) begin cnt++; if (pos == 0) pos = i; end
    end
    check("bounce_one_baja", 32'(cnt), 32'd1);
    check("bounce_baja_pos", 32'(pos), 32'd8);

    // Long press on channel 3: pulse 11 edges after the debounced rise, once.
    btn[3] = 1'b1;
    pos = 0;
    for (int i = 0; i < 20 && pos == 0; i++) begin tick(); if (est[3]) pos = 1; end
    check("long_rise_seen", 32'(pos), 32'd1);
    cnt = 0;
    pos = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (largo[3]) begin cnt++; if (pos == 0) pos = i; end
    end
    check("long_pos",   32'(pos), 32'd11);
    check("long_count", 32'(cnt), 32'd1);
    btn[3] = 1'b0;
    ticks(12);

    // Reset in the middle of a count, then button held through release.
    btn[0] = 1'b1;
    ticks(6);
    rst = 1'b1;
    tick();
    check("midreset_outputs", 32'({est, sube, baja, largo}), 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) check("post_reset_quiet", 32'({sube, baja, largo}), 32'd0);
      if (i == 7) check("post_reset_early", 32'(sube[0]), 32'd0);
      if (i == 8) check("post_reset_sube", 32'(sube[0]), 32'd1);
    end
    btn = '0;
    ticks(12);

    // All channels together.
    btn = 4'hF;
    ticks(7);
    check("all_early", 32'(sube), 32'd0);
    tick();
    check("all_sube", 32'(sube), 32'hF);
    check("all_est",  32'(est),  32'hF);
    btn = 4'h0;
    ticks(8);
    check("all_baja", 32'(baja), 32'hF);
    ticks(4);

    // Random traffic alternating between bouncy and calm phases.
    for (int blk = 0; blk < 16; blk++) begin
      flip_lo = blk[0];
      for (int i = 0; i < 200; i++) begin
        for (int c = 0; c < N; c++) begin
          if (flip_lo ? ($urandom_range(11, 0) == 0) : ($urandom_range(2, 0) == 0))
            btn[c] = ~btn[c];
        end
        rst = ($urandom_range(399, 0) == 0);
        tick();
      end
    end
    rst = 1'b0;
    ticks(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
